pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit that generates the stall, enable and flush controls consumed by the F/D, D/E and E/M pipeline registers of the five-stage MIPS core. It compares the decode-stage instruction against instructions in E and M to insert load-use and branch-operand bubbles. It tracks a multi-cycle multiply/divide unit and sequences external interrupts into a single-cycle pipeline flush with a captured EPC.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles for mult/multu
- DIV_CYC, 10, busy cycles for div/divu
- RESET_PC, 32'h00003000, EPC reset value
Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- IR_D  input  32  instruction in decode
- IR_E  input  32  instruction in execute
- IR_M  input  32  instruction in memory
- PC4_M  input  32  PC+4 of the M-stage instruction
- int_req  input  1  interrupt request from CP0, level
- int_en  input  1  global interrupt enable from CP0
- en  output  1  PC and F/D write enable (0 = hold)
- stall  output  1  D/E bubble insert
- interupt  output  1  flush pulse to F/D, D/E, E/M
- md_busy  output  1  multiply/divide unit busy
- epc  output  32  PC of the interrupted instruction

## Operation
- Decode fields: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], funct=IR[5:0].
- Destination: R-type → rd; lw/lb/lbu/lh/lhu/addi/addiu/ori/andi/lui/slti → rt; jal → 31; else none. Destination 0 counts as none.
- Load-use: IR_E is a load, dest_E ≠ 0, and dest_E equals a source used by IR_D → hazard.
- Branch operand: IR_D is beq/bne/jr/jalr and (dest_E matches an IR_D source) or (IR_M is a load and dest_M matches an IR_D source) → hazard.
- MD hazard: IR_D is mfhi/mflo/mthi/mtlo/mult*/div* and (md_busy or IR_E is mult*/div*) → hazard.
- Any hazard: stall=1, en=0 (combinational). Otherwise stall=0, en=1.
- MD counter: IR_E is mult/multu → load MULT_CYC; div/divu → load DIV_CYC; else decrement to 0. md_busy = (count ≠ 0).
- Interrupt FSM states IDLE, WAIT_MD, FLUSH, HOLD:
  - IDLE: int_req & int_en → WAIT_MD if md_busy, else FLUSH.
  - WAIT_MD: when md_busy=0 → FLUSH.
  - FLUSH: interupt=1 for exactly one cycle; epc ← PC4_M − 4 on entry; → HOLD.
  - HOLD: when int_req=0 → IDLE; this blocks retrigger on the same level.
- While interupt=1: en=1, stall=0; flush overrides hazards.

## Timing
- Reset (rst=0): FSM=IDLE, count=0, interupt=0, md_busy=0, epc=RESET_PC. en and stall follow the combinational hazard logic. With all IRs zero this gives en=1, stall=0.
- Hazard outputs settle in the same cycle; a load-use hazard stalls exactly 1 cycle. A branch depending on an E-stage ALU result stalls 1 cycle; one depending on an E-stage load stalls 2 cycles.
- md_busy rises the cycle after mult/div leaves E and stays high for MULT_CYC/DIV_CYC cycles.
- Interrupt latency from IDLE with md_busy=0: interupt is high in the cycle after int_req is sampled.
- int_en dropping in WAIT_MD → IDLE, with no flush.
- Reset asserted mid-FLUSH: interupt drops immediately, asynchronously.
- Counter reload: a new mult/div in E while busy reloads the count; it does not sum.

## Configuration
- HAZARD_MD_EN defined: MD counter and MD hazard are present, and WAIT_MD is reachable.
- HAZARD_MD_EN undefined: md_busy is tied 0, no MD hazard is raised, and IDLE goes directly to FLUSH.

## Structure
- Shared package (mips_pkg): opcode/funct constants, instruction-class helper functions (is_load, is_branch_d, is_md), FSM state enum, RESET_PC.
- One sub-module: md_busy_cnt, containing the counter with load/decrement and the busy flag.

## Test plan
- IR_E=lw $8,0($0), IR_D=add $9,$8,$1 → stall=1, en=0 for 1 cycle; the next cycle stall=0.
- IR_E=lw $8, IR_D=beq $8,$0 → stall for 2 consecutive cycles, then released.
- IR_E=div, then IR_D=mflo → stall for DIV_CYC+1 cycles total; md_busy high for 10 cycles.
- int_req=1, int_en=1, PC4_M=0x3014, idle MD → interupt=1 for one cycle; epc=0x3010; no second pulse while int_req stays high.
- int_req asserted during a mult → interupt delayed until md_busy=0; rst pulsed low mid-sequence → all outputs at reset values.
- Build without HAZARD_MD_EN: mult then mfhi → no stall; md_busy constantly 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline control logic.
//   - opcode / funct constants used by the hazard decoder
//   - instruction-class helpers (is_load, is_branch_d, is_md, ...)
//   - interrupt sequencer state enum
//   - RESET_PC, the value epc holds out of reset
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_MD = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HOLD    = 2'd3
    } int_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Instructions that resolve in D and therefore need their operands early
    function automatic logic is_branch_d(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_RTYPE) && ((funct == F_JR) || (funct == F_JALR)));
    endfunction

    function automatic logic is_mult(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == F_MULT) || (funct == F_MULTU));
    endfunction

    function automatic logic is_div(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == F_DIV) || (funct == F_DIVU));
    endfunction

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] funct);
        return is_mult(op, funct) || is_div(op, funct);
    endfunction

    // Anything in D that touches HI/LO or starts a new multiply/divide
    function automatic logic is_md_d(input logic [5:0] op, input logic [5:0] funct);
        return is_md(op, funct) ||
               ((op == OP_RTYPE) && ((funct == F_MFHI) || (funct == F_MTHI) ||
                                     (funct == F_MFLO) || (funct == F_MTLO)));
    endfunction

    // Register written by an instruction; 0 means "writes nothing"
    function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == OP_RTYPE)
            d = rd;
        else if (is_load(op) || (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI) ||
                 (op == OP_ANDI) || (op == OP_LUI) || (op == OP_SLTI))
            d = rt;
        else if (op == OP_JAL)
            d = 5'd31;
        return d;
    endfunction

    // True when a nonzero register r is read by the instruction (op, rs, rt).
    // rs is read by everything except j/jal/lui; rt is read by R-type,
    // beq/bne and the stores.
    function automatic logic reads_reg(input logic [4:0] r, input logic [5:0] op,
                                       input logic [4:0] rs, input logic [4:0] rt);
        logic rs_used;
        logic rt_used;
        rs_used = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
        rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                  (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        return (r != 5'd0) && ((rs_used && (rs == r)) || (rt_used && (rt == r)));
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: busy tracker for the multi-cycle multiply/divide unit.
//   clk       pipeline clock
//   rst       asynchronous active-low reset
//   load_mult mult/multu in E this cycle: reload count with MULT_CYC
//   load_div  div/divu in E this cycle: reload count with DIV_CYC
//   busy      count is nonzero
// A reload always overwrites the remaining count rather than adding to it.
module md_busy_cnt #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load_mult,
    input  logic load_div,
    output logic busy
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load_mult)
            count_next = CW'(MULT_CYC);
        else if (load_div)
            count_next = CW'(DIV_CYC);
        else if (count_reg != '0)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign busy = (count_reg != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / enable / flush generation for the 5-stage MIPS core.
//   clk       pipeline clock
//   rst       asynchronous active-low reset
//   IR_D/E/M  instructions in decode / execute / memory
//   PC4_M     PC+4 of the M-stage instruction (epc source)
//   int_req   level interrupt request, int_en global enable
//   en        PC and F/D write enable (0 = hold)
//   stall     insert bubble into D/E
//   interupt  one-cycle flush of F/D, D/E, E/M
//   md_busy   multiply/divide unit busy
//   epc       PC of the interrupted instruction
// Build option: define HAZARD_MD_EN to enable multiply/divide tracking
// (busy counter, HI/LO hazard, waiting for the unit before flushing).
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int          MULT_CYC = 5,
    parameter int          DIV_CYC  = 10,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC4_M,
    input  logic        int_req,
    input  logic        int_en,
    output logic        en,
    output logic        stall,
    output logic        interupt,
    output logic        md_busy,
    output logic [31:0] epc
);

    int_state_t  state_reg;
    int_state_t  state_next;
    logic [31:0] epc_reg;
    logic [4:0]  dest_e;
    logic [4:0]  dest_m;
    logic        src_hit_e;
    logic        src_hit_m;
    logic        load_use_haz;
    logic        branch_haz;
    logic        md_haz;
    logic        load_mult;
    logic        load_div;
    logic        unused_bits;

    // Only some instruction fields matter per stage; fold the rest here.
    assign unused_bits = ^{IR_D, IR_E, IR_M};

    assign dest_e    = dest_reg(IR_E[31:26], IR_E[20:16], IR_E[15:11]);
    assign dest_m    = dest_reg(IR_M[31:26], IR_M[20:16], IR_M[15:11]);
    assign src_hit_e = reads_reg(dest_e, IR_D[31:26], IR_D[25:21], IR_D[20:16]);
    assign src_hit_m = reads_reg(dest_m, IR_D[31:26], IR_D[25:21], IR_D[20:16]);

    assign load_use_haz = is_load(IR_E[31:26]) && src_hit_e;

    // Branches compare in D: an E-stage ALU result is one cycle away, a
    // load is still unresolved in M, so it costs a second bubble.
    assign branch_haz = is_branch_d(IR_D[31:26], IR_D[5:0]) &&
                        (src_hit_e || (is_load(IR_M[31:26]) && src_hit_m));

`ifdef HAZARD_MD_EN
    assign load_mult = is_mult(IR_E[31:26], IR_E[5:0]);
    assign load_div  = is_div(IR_E[31:26], IR_E[5:0]);
    assign md_haz    = is_md_d(IR_D[31:26], IR_D[5:0]) &&
                       (md_busy || is_md(IR_E[31:26], IR_E[5:0]));
`else
    // Counter never loads, so md_busy stays 0.
    assign load_mult = 1'b0;
    assign load_div  = 1'b0;
    assign md_haz    = 1'b0;
`endif

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_mult (load_mult),
        .load_div  (load_div),
        .busy      (md_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            epc_reg   <= RESET_PC;
        end else begin
            state_reg <= state_next;
            if ((state_next == ST_FLUSH) && (state_reg != ST_FLUSH))
                epc_reg <= PC4_M - 32'd4;
        end
    end

    always_comb begin
        state_next = state_reg;
        interupt   = 1'b0;
        stall      = 1'b0;
        en         = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (int_req && int_en) begin
`ifdef HAZARD_MD_EN
                    state_next = md_busy ? ST_WAIT_MD : ST_FLUSH;
`else
                    state_next = ST_FLUSH;
`endif
                end
            end
            ST_WAIT_MD: begin
                if (!int_en)
                    state_next = ST_IDLE;
                else if (!md_busy)
                    state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                interupt   = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for the request level to drop before re-arming.
                if (!int_req)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // The flush empties the pipe, so any hazard it would stall on is gone.
        if (!interupt && (load_use_haz || branch_haz || md_haz)) begin
            stall = 1'b1;
            en    = 1'b0;
        end
    end

    assign epc = epc_reg;

endmodule
